fetch_stage: RTL and testbench

- Front-end fetch stage.
- Holds the PC and issues 32-bit instruction reads to the instruction memory port.
- Buffers returned words, with their PCs, in a small output FIFO, and hands them to the decode stage with a valid/ready handshake.
- Accepts a redirect from the back end (branch/jump resolution): it flushes the FIFO and squashes any in-flight read.

---
 rtl/fetch_stage.sv | 210 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Front-end fetch stage: holds the PC, keeps one instruction read in flight, and buffers
// returned words with their PCs in a small FIFO toward decode. A redirect flushes and squashes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc_curr,
  output logic [31:0] out_pc_next,
  output logic [31:0] out_inst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [31:0]   pcn_mem_q  [DEPTH];
  logic [31:0]   pcn_mem_d  [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic          full_s;
  logic          empty_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    rmask_s;
  logic [31:0]   addr_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign wr_idx_s = wr_ptr_q[AW-1:0];
  assign rd_idx_s = rd_ptr_q[AW-1:0];
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx_s == rd_idx_s);
  // A read is only started while held out of reset and with a free slot for its word.
  assign issue_s  = (state_q == IDLE) && !full_s && rst;

  // Next-state, read request, FIFO push/pop and redirect handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    pcn_mem_d  = pcn_mem_q;
    inst_mem_d = inst_mem_q;
    rmask_s    = 4'h0;
    addr_s     = addr_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;

    case (state_q)
      IDLE: begin
        addr_s = pc_q;
        if (issue_s) begin
          rmask_s = 4'hF;
          addr_d  = pc_q;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        rmask_s = 4'hF;
        if (imem_resp) begin
          push_s  = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DISCARD: begin
        rmask_s = 4'hF;
        if (imem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      // A read issued this cycle targets the stale pc, so it must be drained as squashed.
      push_s   = 1'b0;
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      case (state_q)
        IDLE:          state_d = issue_s ? DISCARD : IDLE;
        WAIT, DISCARD: state_d = imem_resp ? IDLE : DISCARD;
        default:       state_d = IDLE;
      endcase
    end else begin
      pop_s = !empty_s && out_ready;
      if (push_s) begin
        pc_mem_d[wr_idx_s]   = pc_q;
        pcn_mem_d[wr_idx_s]  = pc_q + 32'd4;
        inst_mem_d[wr_idx_s] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State, PC, outstanding address, pointers and FIFO storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= 32'd0;
        pcn_mem_q[i]  <= 32'd0;
        inst_mem_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      pcn_mem_q  <= pcn_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  assign imem_rmask  = rmask_s;
  assign imem_addr   = addr_s;
  assign out_valid   = !empty_s;
  assign out_pc_curr = empty_s ? 32'd0 : pc_mem_q[rd_idx_s];
  assign out_pc_next = empty_s ? 32'd0 : pcn_mem_q[rd_idx_s];
  assign out_inst    = empty_s ? 32'd0 : inst_mem_q[rd_idx_s];

  fetch_stage_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .full       (full_s),
    .rmask      (rmask_s),
    .addr       (addr_s),
    .resp       (imem_resp),
    .out_valid  (out_valid),
    .pc_curr    (out_pc_curr),
    .pc_next    (out_pc_next)
  );

endmodule

// Invariant checker for fetch_stage: FIFO overflow, request address stability, PC pairing.
module fetch_stage_chk (
  input logic        clk,
  input logic        rst,
  input logic        push,
  input logic        full,
  input logic [3:0]  rmask,
  input logic [31:0] addr,
  input logic        resp,
  input logic        out_valid,
  input logic [31:0] pc_curr,
  input logic [31:0] pc_next
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) push |-> !full);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (rmask != 4'h0 && !resp) |=> (rmask == 4'h0 || addr == $past(addr)));

  a_pc_next: assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> (pc_next == pc_curr + 32'd4));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_curr;
  logic [31:0] out_pc_next;
  logic [31:0] out_inst;

  int total = 0;
  int bad   = 0;

  int          lat = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  int          resp_total = 0;
  int          rmask_cnt = 0;
  int          rmask_rst_cnt = 0;

  logic [31:0] pcq[$];
  logic [31:0] pcnq[$];
  logic [31:0] instq[$];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc_curr    (out_pc_curr),
    .out_pc_next    (out_pc_next),
    .out_inst       (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5ac3c3;
  endfunction

  // Memory model: response arrives lat cycles after the issue cycle.
  always @(negedge clk) begin
    logic prev;
    if (!rst) begin
      mem_busy   = 1'b0;
      mem_cnt    = 0;
      imem_resp  = 1'b0;
      imem_rdata = 32'd0;
      if (imem_rmask != 4'h0) rmask_rst_cnt++;
    end else begin
      prev       = imem_resp;
      imem_resp  = 1'b0;
      imem_rdata = 32'hdeadbeef;
      if (prev) mem_busy = 1'b0;
      if (imem_rmask != 4'h0) begin
        rmask_cnt++;
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = 0;
          mem_addr = imem_addr;
        end else begin
          mem_cnt++;
        end
        if (mem_cnt >= lat) begin
          imem_resp  = 1'b1;
          imem_rdata = inst_of(mem_addr);
          resp_total++;
        end
      end
    end
  end

  // Record every word decode actually takes.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !redirect_valid) begin
      pcq.push_back(out_pc_curr);
      pcnq.push_back(out_pc_next);
      instq.push_back(out_inst);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (pcq.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check("word_count", 32'(pcq.size()), 32'(n));
  endtask

  task automatic wait_mem(input int c, input int budget);
    int k = 0;
    while (!(mem_busy && mem_cnt == c && !imem_resp) && k < budget) begin
      cyc(1);
      k++;
    end
    check("mem_sync", {31'd0, (mem_busy && mem_cnt == c)}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int rm0;
    logic [31:0] e;
    logic [31:0] stale;

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    lat            = 1;

    // Reset state
    cyc(3);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rmask", {28'd0, imem_rmask}, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_pc_curr", out_pc_curr, 32'd0);
    check("rst_pc_next", out_pc_next, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rmask_in_rst", 32'(rmask_rst_cnt), 32'd0);

    // In-order fetch from RESET_PC at latency 1
    rst = 1'b1;
    wait_words(3, 40);
    check("seq0_pc", pcq[0], 32'h1eceb000);
    check("seq1_pc", pcq[1], 32'h1eceb004);
    check("seq2_pc", pcq[2], 32'h1eceb008);
    check("seq0_pcn", pcnq[0], 32'h1eceb004);
    check("seq2_pcn", pcnq[2], 32'h1eceb00c);
    check("seq1_inst", instq[1], inst_of(32'h1eceb004));

    // Backpressure: FIFO fills to DEPTH, no further reads, then drains in order
    out_ready = 1'b0;
    cyc(8);
    rm0 = rmask_cnt;
    cyc(12);
    check("full_no_rmask", 32'(rmask_cnt - rm0), 32'd0);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    e = RST_PC + 32'(4 * pcq.size());
    check("full_head", out_pc_curr, e);
    out_ready = 1'b1;
    cyc(1);
    check("drain_valid1", {31'd0, out_valid}, 32'd1);
    check("drain_head1", out_pc_curr, e + 32'd4);
    cyc(1);
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    n = pcq.size();
    wait_words(n + 2, 30);
    for (int i = 0; i < pcq.size(); i++) begin
      check("stream_pc", pcq[i], RST_PC + 32'(4 * i));
    end

    // Redirect while WAIT at latency 3: stale word dropped
    lat = 3;
    wait_mem(1, 50);
    stale = mem_addr;
    n = pcq.size();
    do_redirect(32'h1eceb100);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    check("discard_rmask", {28'd0, imem_rmask}, 32'h0000000f);
    check("discard_addr", imem_addr, stale);
    wait_words(n + 2, 60);
    check("redir_pc0", pcq[n], 32'h1eceb100);
    check("redir_inst0", instq[n], inst_of(32'h1eceb100));
    check("redir_pc1", pcq[n + 1], 32'h1eceb104);

    // Redirect coincident with imem_resp: no push, target issued next cycle
    wait_mem(2, 50);
    n = pcq.size();
    do_redirect(32'h1eceb203);
    check("resp_redir_addr", imem_addr, 32'h1eceb200);
    check("resp_redir_rmask", {28'd0, imem_rmask}, 32'h0000000f);
    check("resp_redir_flush", {31'd0, out_valid}, 32'd0);
    wait_words(n + 1, 60);
    check("resp_redir_pc", pcq[n], 32'h1eceb200);

    // Back-to-back redirects into DISCARD: only the second stream is delivered
    wait_mem(0, 50);
    n  = pcq.size();
    r0 = resp_total;
    do_redirect(32'h00000100);
    do_redirect(32'h00000200);
    wait_words(n + 3, 80);
    check("b2b_pc0", pcq[n], 32'h00000200);
    check("b2b_pc1", pcq[n + 1], 32'h00000204);
    check("b2b_pc2", pcq[n + 2], 32'h00000208);
    check("b2b_resp_cnt", 32'(resp_total - r0), 32'd4);

    // PC wraparound at the top of the address space
    lat = 1;
    n = pcq.size();
    do_redirect(32'hfffffffc);
    wait_words(n + 2, 40);
    check("wrap_pc", pcq[n], 32'hfffffffc);
    check("wrap_pcn", pcnq[n], 32'h00000000);
    check("wrap_inst", instq[n], inst_of(32'hfffffffc));
    check("wrap_next_pc", pcq[n + 1], 32'h00000000);
    check("wrap_next_pcn", pcnq[n + 1], 32'h00000004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
